chan_mux_rr: RTL and testbench
==============================

CHAN_MUX_RR -- requirements
Module: chan_mux_rr

Interface
REQ-001 Parameter WIDTH, default 3: data bits per channel; legal range >= 1.
REQ-002 Parameter NCH, default 4: input channel count; legal range >= 2.
REQ-003 Derived constant SEL_W = max(1, clog2(NCH)); not overridable.
REQ-004 Port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-005 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 Port in_data, input, NCH*WIDTH bits: channel i occupies bits [i*WIDTH +: WIDTH].
REQ-007 Port in_valid, input, NCH bits: per-channel valid.
REQ-008 Port in_ready, output, NCH bits: per-channel ready.
REQ-009 Port mode, input, 1 bit: 0 = manual select, 1 = round-robin.
REQ-010 Port sel, input, SEL_W bits: channel index used in manual mode.
REQ-011 Port out_data, output, WIDTH bits: registered selected data.
REQ-012 Port out_chan, output, SEL_W bits: source channel index of out_data.
REQ-013 Port out_valid, output, 1 bit: out_data/out_chan hold an unconsumed word.
REQ-014 Port out_ready, input, 1 bit: downstream accepts the current output word.

Function
REQ-015 load_en SHALL equal (!out_valid || out_ready).
REQ-016 In manual mode, grant SHALL be channel sel if sel < NCH and in_valid[sel] = 1; otherwise there is no grant.
REQ-017 In round-robin mode, grant SHALL be the first channel with in_valid = 1, searching ptr+1, ptr+2, ... modulo NCH, ending at ptr.
REQ-018 in_ready[i] SHALL be load_en AND (grant == i); at most one in_ready bit is high per cycle.
REQ-019 When in_valid[i] and in_ready[i] are both high, the next cycle SHALL show out_valid = 1, out_data = in_data[i], out_chan = i; latency is 1 cycle.
REQ-020 ptr SHALL update to i on every accepted transfer in either mode, and hold otherwise.
REQ-021 If load_en = 1 and there is no grant, out_valid SHALL become 0 next cycle; out_data and out_chan hold their values.
REQ-022 While out_valid = 1 and out_ready = 0, out_data, out_chan and out_valid SHALL remain stable, and all in_ready bits SHALL be 0.
REQ-023 Simultaneous out_ready and a new grant SHALL replace the output word in the same edge; sustained throughput is 1 word/cycle.
REQ-024 mode and sel SHALL be sampled combinationally each cycle; changing them SHALL NOT alter a word already registered.
REQ-025 Channels with in_valid = 0 SHALL never be granted, and a granted channel SHALL never be skipped.

Reset
REQ-026 On rst = 1 at a clock edge: out_valid = 0, out_data = 0, out_chan = 0, ptr = NCH-1, so that channel 0 has first round-robin priority.
REQ-027 While rst = 1, all in_ready bits SHALL be 0; no transfer occurs.
REQ-028 rst asserted mid-operation SHALL discard any held output word without handshake.

Configuration
REQ-029 Macro CHAN_MUX_RR_PARITY_EN defined: add output port out_par (1 bit), registered with out_data, equal to the XOR of the loaded data bits (even parity); it resets to 0 and holds under stall.
REQ-030 Macro CHAN_MUX_RR_PARITY_EN undefined: out_par port and its logic SHALL be absent; all other behaviour is identical.

Structure
REQ-031 Shared package chan_mux_pkg SHALL hold mode constants MODE_MANUAL = 1'b0 and MODE_RR = 1'b1.
REQ-032 Sub-module rr_arbiter (parameter NCH; inputs req[NCH], ptr[SEL_W]; output one-hot gnt[NCH]) SHALL implement REQ-017; mode muxing and the output register live in chan_mux_rr.

Verification
REQ-033 Manual mode, NCH = 4, WIDTH = 3, out_ready = 1, sel = 2, in_valid = 4'b1111, ch2 data = 3'b101 -> in_ready = 4'b0100; next cycle out_data = 3'b101, out_chan = 2.
REQ-034 Round-robin mode, all four channels valid continuously, out_ready = 1 -> out_chan sequence 0, 1, 2, 3, 0 on consecutive cycles.
REQ-035 Round-robin mode, only ch1 and ch3 valid -> grants alternate 1, 3, 1, 3; ch0 and ch2 in_ready stay 0.
REQ-036 Word held with out_ready = 0 for 3 cycles while inputs change -> out_data and out_chan are stable and in_ready = 0; on out_ready = 1 the next grant loads on the same edge.
REQ-037 Manual mode, sel = 1, in_valid[1] = 0 -> no ready; once out_ready drains the word, out_valid = 0. Also with NCH = 3, sel = 3 -> no grant.
REQ-038 rst asserted with out_valid = 1 -> next cycle out_valid = 0 and out_data = 0; first round-robin grant after reset, with all channels valid, is ch0; with CHAN_MUX_RR_PARITY_EN, data 3'b111 -> out_par = 1.

Source files
------------

// File: rtl/chan_mux_pkg.sv
// Shared constants for the channel mux: mode encodings and select-width helper.
package chan_mux_pkg;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_RR     = 1'b1;

  // Select width never drops below one bit, even for two channels.
  function automatic int sel_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Rotating-priority arbiter: first requester after ptr wins, wrapping back to ptr last.
module rr_arbiter
  import chan_mux_pkg::*;
#(
  parameter  int NCH   = 4,
  localparam int SEL_W = sel_width(NCH)
) (
  input  logic [NCH-1:0]   req,
  input  logic [SEL_W-1:0] ptr,
  output logic [NCH-1:0]   gnt
);

  always_comb begin
    gnt = '0;
    for (int k = 1; k <= NCH; k++) begin
      if ((gnt == '0) && req[(int'(ptr) + k) % NCH]) begin
        gnt[(int'(ptr) + k) % NCH] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/chan_mux_rr.sv
// N-channel to one registered mux, manual or round-robin selection, valid/ready both sides.
// Optional even-parity output enabled by defining CHAN_MUX_RR_PARITY_EN.
module chan_mux_rr
  import chan_mux_pkg::*;
#(
  parameter  int WIDTH = 3,
  parameter  int NCH   = 4,
  localparam int SEL_W = sel_width(NCH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NCH*WIDTH-1:0]   in_data,
  input  logic [NCH-1:0]         in_valid,
  output logic [NCH-1:0]         in_ready,
  input  logic                   mode,
  input  logic [SEL_W-1:0]       sel,
  output logic [WIDTH-1:0]       out_data,
  output logic [SEL_W-1:0]       out_chan,
  output logic                   out_valid,
  input  logic                   out_ready
`ifdef CHAN_MUX_RR_PARITY_EN
  ,
  output logic                   out_par
`endif
);

  // Channel 0 gets first round-robin priority out of reset.
  localparam logic [SEL_W-1:0] PTR_RST = SEL_W'(NCH - 1);

  logic                 r_vld_p1;
  logic [WIDTH-1:0]     r_data_p1;
  logic [SEL_W-1:0]     r_chan_p1;
  logic [SEL_W-1:0]     r_ptr;

  logic                 w_load_en;
  logic [NCH-1:0]       w_man_gnt;
  logic [NCH-1:0]       w_rr_gnt;
  logic [NCH-1:0]       w_gnt;
  logic                 w_xfer;
  logic [WIDTH-1:0]     w_data_sel;
  logic [SEL_W-1:0]     w_chan_sel;

`ifdef CHAN_MUX_RR_PARITY_EN
  logic                 r_par_p1;

  function automatic logic even_par(input logic [WIDTH-1:0] d);
    return ^d;
  endfunction
`endif

  assign w_load_en = !r_vld_p1 || out_ready;

  // sel may exceed NCH-1 when NCH is not a power of two; such a select grants nothing.
  always_comb begin
    w_man_gnt = '0;
    if (int'(sel) < NCH) begin
      w_man_gnt[sel] = in_valid[sel];
    end
  end

  rr_arbiter #(
    .NCH (NCH)
  ) u_arb (
    .req (in_valid),
    .ptr (r_ptr),
    .gnt (w_rr_gnt)
  );

  assign w_gnt    = (mode == MODE_RR) ? w_rr_gnt : w_man_gnt;
  assign in_ready = (w_load_en && !rst) ? w_gnt : '0;
  assign w_xfer   = |in_ready;

  always_comb begin
    w_data_sel = '0;
    w_chan_sel = '0;
    for (int i = 0; i < NCH; i++) begin
      if (w_gnt[i]) begin
        w_data_sel = in_data[i*WIDTH +: WIDTH];
        w_chan_sel = SEL_W'(i);
      end
    end
  end

  // Stage p1: output word register, loaded whenever the slot is free or being drained.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_p1  <= 1'b0;
      r_data_p1 <= '0;
      r_chan_p1 <= '0;
      r_ptr     <= PTR_RST;
`ifdef CHAN_MUX_RR_PARITY_EN
      r_par_p1  <= 1'b0;
`endif
    end else if (w_load_en) begin
      r_vld_p1 <= w_xfer;
      if (w_xfer) begin
        r_data_p1 <= w_data_sel;
        r_chan_p1 <= w_chan_sel;
        r_ptr     <= w_chan_sel;
`ifdef CHAN_MUX_RR_PARITY_EN
        r_par_p1  <= even_par(w_data_sel);
`endif
      end
    end
  end

  assign out_valid = r_vld_p1;
  assign out_data  = r_data_p1;
  assign out_chan  = r_chan_p1;
`ifdef CHAN_MUX_RR_PARITY_EN
  assign out_par   = r_par_p1;
`endif

endmodule

// File: tb/tb_chan_mux_rr.sv
// Bench for chan_mux_rr: 4-channel instance with scoreboard plus a 3-channel instance for out-of-range select.
module tb_chan_mux_rr;
  import chan_mux_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] in_data = '0;
  logic [3:0]  in_valid = '0;
  logic [3:0]  in_ready;
  logic        mode = MODE_RR;
  logic [1:0]  sel = '0;
  logic [2:0]  out_data;
  logic [1:0]  out_chan;
  logic        out_valid;
  logic        out_ready = 1'b1;

  logic [8:0]  in_data3 = '0;
  logic [2:0]  in_valid3 = '0;
  logic [2:0]  in_ready3;
  logic        mode3 = MODE_MANUAL;
  logic [1:0]  sel3 = '0;
  logic [2:0]  out_data3;
  logic [1:0]  out_chan3;
  logic        out_valid3;
  logic        out_ready3 = 1'b1;
`ifdef CHAN_MUX_RR_PARITY_EN
  logic        out_par;
  logic        out_par3;
`endif

  chan_mux_rr #(.WIDTH(3), .NCH(4)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .sel(sel), .out_data(out_data), .out_chan(out_chan),
    .out_valid(out_valid), .out_ready(out_ready)
`ifdef CHAN_MUX_RR_PARITY_EN
    , .out_par(out_par)
`endif
  );

  chan_mux_rr #(.WIDTH(3), .NCH(3)) dut3 (
    .clk(clk), .rst(rst), .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
    .mode(mode3), .sel(sel3), .out_data(out_data3), .out_chan(out_chan3),
    .out_valid(out_valid3), .out_ready(out_ready3)
`ifdef CHAN_MUX_RR_PARITY_EN
    , .out_par(out_par3)
`endif
  );

  always #5 clk = ~clk;

  int         total = 0;
  int         bad   = 0;
  logic [4:0] sb[$];
  logic       m_vld = 1'b0;
  int         m_ptr = 3;
  logic       p_load = 1'b0;
  logic       p_any = 1'b0;
  int         p_chan = 0;

  function automatic int model_grant(input logic m, input logic [1:0] s, input logic [3:0] v, input int p);
    if (m == MODE_MANUAL) return v[s] ? int'(s) : -1;
    for (int k = 1; k <= 4; k++) begin
      if (v[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  task automatic drive(input logic m, input logic [1:0] s, input logic [3:0] v,
                       input logic [11:0] d, input logic ordy, output logic [3:0] er);
    int g;
    @(negedge clk);
    mode = m; sel = s; in_valid = v; in_data = d; out_ready = ordy;
    #1;
    p_load = !m_vld || ordy;
    g = model_grant(m, s, v, m_ptr);
    er = '0;
    p_any = 1'b0;
    if (p_load && g >= 0) begin
      er[g]  = 1'b1;
      p_any  = 1'b1;
      p_chan = g;
      sb.push_back({2'(g), d[g*3 +: 3]});
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (p_load) begin
      m_vld = p_any;
      if (p_any) m_ptr = p_chan;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; mode = MODE_RR; in_valid = 4'hF; in_data = 12'hABC; out_ready = 1'b1;
    @(negedge clk); #1;
    total++;
    if (in_ready !== 4'b0000) begin bad++; $display("FAIL reset_ready got=%b want=0000", in_ready); end
    @(posedge clk); #1;
    total++;
    if (out_valid !== 1'b0 || out_data !== 3'b000 || out_chan !== 2'd0) begin
      bad++; $display("FAIL reset_out got vld=%b data=%b chan=%0d want 0/000/0", out_valid, out_data, out_chan);
    end
    @(negedge clk);
    rst = 1'b0; in_valid = '0;
    m_vld = 1'b0; m_ptr = 3; sb.delete();
  endtask

  task automatic test_rr_all();
    logic [3:0] er;
    logic [4:0] exp;
    int seq[5] = '{0, 1, 2, 3, 0};
    for (int k = 0; k < 5; k++) begin
      drive(MODE_RR, 2'd0, 4'hF, 12'($urandom), 1'b1, er);
      total++;
      if (in_ready !== er) begin bad++; $display("FAIL rr_all_ready[%0d] got=%b want=%b", k, in_ready, er); end
      tick();
      if (p_any) begin
        exp = sb.pop_front();
        total++;
        if ({out_chan, out_data} !== exp || out_valid !== 1'b1) begin
          bad++; $display("FAIL rr_all_word[%0d] got=%b want=%b", k, {out_chan, out_data}, exp);
        end
      end
      total++;
      if (out_chan !== 2'(seq[k])) begin bad++; $display("FAIL rr_all_seq[%0d] got=%0d want=%0d", k, out_chan, seq[k]); end
    end
  endtask

  task automatic test_rr_sparse();
    logic [3:0] er;
    logic [4:0] exp;
    int seq[4] = '{1, 3, 1, 3};
    for (int k = 0; k < 4; k++) begin
      drive(MODE_RR, 2'd0, 4'b1010, 12'($urandom), 1'b1, er);
      total++;
      if (in_ready !== er || in_ready[0] !== 1'b0 || in_ready[2] !== 1'b0) begin
        bad++; $display("FAIL rr_sparse_ready[%0d] got=%b want=%b", k, in_ready, er);
      end
      tick();
      if (p_any) begin
        exp = sb.pop_front();
        total++;
        if ({out_chan, out_data} !== exp) begin
          bad++; $display("FAIL rr_sparse_word[%0d] got=%b want=%b", k, {out_chan, out_data}, exp);
        end
      end
      total++;
      if (out_chan !== 2'(seq[k])) begin bad++; $display("FAIL rr_sparse_seq[%0d] got=%0d want=%0d", k, out_chan, seq[k]); end
    end
  endtask

  task automatic test_manual();
    logic [3:0] er;
    logic [4:0] exp;
    drive(MODE_MANUAL, 2'd2, 4'hF, {3'b001, 3'b101, 3'b010, 3'b011}, 1'b1, er);
    total++;
    if (in_ready !== 4'b0100) begin bad++; $display("FAIL manual_ready got=%b want=0100", in_ready); end
    tick();
    exp = sb.pop_front();
    total++;
    if (out_data !== 3'b101 || out_chan !== 2'd2 || {out_chan, out_data} !== exp) begin
      bad++; $display("FAIL manual_word got data=%b chan=%0d want data=101 chan=2", out_data, out_chan);
    end
    drive(MODE_MANUAL, 2'd0, 4'b0011, {3'b111, 3'b110, 3'b100, 3'b010}, 1'b1, er);
    total++;
    if (in_ready !== er) begin bad++; $display("FAIL manual_ready_sel0 got=%b want=%b", in_ready, er); end
    tick();
    exp = sb.pop_front();
    total++;
    if ({out_chan, out_data} !== exp) begin bad++; $display("FAIL manual_word_sel0 got=%b want=%b", {out_chan, out_data}, exp); end
  endtask

  task automatic test_stall();
    logic [3:0] er;
    logic [4:0] exp;
    logic [4:0] held;
    drive(MODE_RR, 2'd0, 4'hF, 12'($urandom), 1'b1, er);
    tick();
    exp = sb.pop_front();
    total++;
    if ({out_chan, out_data} !== exp) begin bad++; $display("FAIL stall_load got=%b want=%b", {out_chan, out_data}, exp); end
    held = exp;
    for (int k = 0; k < 3; k++) begin
      drive(MODE_RR, 2'(k), 4'($urandom) | 4'b0001, 12'($urandom), 1'b0, er);
      total++;
      if (in_ready !== 4'b0000) begin bad++; $display("FAIL stall_ready[%0d] got=%b want=0000", k, in_ready); end
      tick();
      total++;
      if ({out_chan, out_data} !== held || out_valid !== 1'b1) begin
        bad++; $display("FAIL stall_hold[%0d] got=%b vld=%b want=%b vld=1", k, {out_chan, out_data}, out_valid, held);
      end
    end
    drive(MODE_RR, 2'd0, 4'hF, 12'($urandom), 1'b1, er);
    total++;
    if (in_ready !== er || er == 4'b0000) begin bad++; $display("FAIL stall_release_ready got=%b want=%b", in_ready, er); end
    tick();
    exp = sb.pop_front();
    total++;
    if ({out_chan, out_data} !== exp || out_valid !== 1'b1) begin
      bad++; $display("FAIL stall_release_word got=%b want=%b", {out_chan, out_data}, exp);
    end
  endtask

  task automatic test_no_grant();
    logic [3:0] er;
    logic [4:0] exp;
    drive(MODE_MANUAL, 2'd0, 4'b1101, 12'o3456, 1'b1, er);
    tick();
    exp = sb.pop_front();
    total++;
    if ({out_chan, out_data} !== exp) begin bad++; $display("FAIL nogrant_load got=%b want=%b", {out_chan, out_data}, exp); end
    drive(MODE_MANUAL, 2'd1, 4'b1101, 12'o7012, 1'b0, er);
    total++;
    if (in_ready !== 4'b0000) begin bad++; $display("FAIL nogrant_ready_stall got=%b want=0000", in_ready); end
    tick();
    drive(MODE_MANUAL, 2'd1, 4'b1101, 12'o7012, 1'b1, er);
    total++;
    if (in_ready !== 4'b0000) begin bad++; $display("FAIL nogrant_ready got=%b want=0000", in_ready); end
    tick();
    total++;
    if (out_valid !== 1'b0 || {out_chan, out_data} !== exp) begin
      bad++; $display("FAIL nogrant_drain got vld=%b word=%b want vld=0 word=%b", out_valid, {out_chan, out_data}, exp);
    end
  endtask

  task automatic test_nch3();
    @(negedge clk);
    mode3 = MODE_MANUAL; sel3 = 2'd3; in_valid3 = 3'b111; in_data3 = {3'b110, 3'b011, 3'b001}; out_ready3 = 1'b1;
    #1;
    total++;
    if (in_ready3 !== 3'b000) begin bad++; $display("FAIL nch3_sel3_ready got=%b want=000", in_ready3); end
    @(posedge clk); #1;
    total++;
    if (out_valid3 !== 1'b0) begin bad++; $display("FAIL nch3_sel3_valid got=%b want=0", out_valid3); end
    @(negedge clk);
    sel3 = 2'd2;
    #1;
    total++;
    if (in_ready3 !== 3'b100) begin bad++; $display("FAIL nch3_sel2_ready got=%b want=100", in_ready3); end
    @(posedge clk); #1;
    total++;
    if (out_valid3 !== 1'b1 || out_data3 !== 3'b110 || out_chan3 !== 2'd2) begin
      bad++; $display("FAIL nch3_sel2_word got vld=%b data=%b chan=%0d want 1/110/2", out_valid3, out_data3, out_chan3);
    end
    @(negedge clk);
    in_valid3 = '0;
  endtask

  task automatic test_mid_reset();
    logic [3:0] er;
    logic [4:0] exp;
    drive(MODE_RR, 2'd0, 4'hF, 12'o7777, 1'b0, er);
    tick();
    exp = sb.pop_front();
    total++;
    if ({out_chan, out_data} !== exp || out_valid !== 1'b1) begin
      bad++; $display("FAIL midrst_load got=%b vld=%b want=%b vld=1", {out_chan, out_data}, out_valid, exp);
    end
    @(negedge clk);
    rst = 1'b1; out_ready = 1'b0;
    #1;
    total++;
    if (in_ready !== 4'b0000) begin bad++; $display("FAIL midrst_ready got=%b want=0000", in_ready); end
    @(posedge clk); #1;
    total++;
    if (out_valid !== 1'b0 || out_data !== 3'b000 || out_chan !== 2'd0) begin
      bad++; $display("FAIL midrst_out got vld=%b data=%b chan=%0d want 0/000/0", out_valid, out_data, out_chan);
    end
    @(negedge clk);
    rst = 1'b0; in_valid = '0;
    m_vld = 1'b0; m_ptr = 3; sb.delete();
    drive(MODE_RR, 2'd0, 4'hF, {3'b001, 3'b010, 3'b101, 3'b111}, 1'b1, er);
    total++;
    if (in_ready !== 4'b0001) begin bad++; $display("FAIL midrst_first_ready got=%b want=0001", in_ready); end
    tick();
    exp = sb.pop_front();
    total++;
    if (out_chan !== 2'd0 || out_data !== 3'b111 || {out_chan, out_data} !== exp) begin
      bad++; $display("FAIL midrst_first_word got data=%b chan=%0d want data=111 chan=0", out_data, out_chan);
    end
`ifdef CHAN_MUX_RR_PARITY_EN
    total++;
    if (out_par !== 1'b1) begin bad++; $display("FAIL parity_111 got=%b want=1", out_par); end
`endif
    drive(MODE_RR, 2'd0, 4'hF, {3'b001, 3'b010, 3'b101, 3'b111}, 1'b1, er);
    tick();
    exp = sb.pop_front();
    total++;
    if (out_chan !== 2'd1 || out_data !== 3'b101 || {out_chan, out_data} !== exp) begin
      bad++; $display("FAIL midrst_second_word got data=%b chan=%0d want data=101 chan=1", out_data, out_chan);
    end
`ifdef CHAN_MUX_RR_PARITY_EN
    total++;
    if (out_par !== 1'b0) begin bad++; $display("FAIL parity_101 got=%b want=0", out_par); end
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_rr_all();
    test_rr_sparse();
    test_manual();
    test_stall();
    test_no_grant();
    test_nch3();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
